// File: rtl/mem_access_stage_pkg.sv
// Shared encodings for the memory-access stage: FSM states and
// writeback output-source codes.
package mem_access_stage_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] SRS_OUT_ALU = 2'd0;
    localparam logic [1:0] SRS_OUT_MEM = 2'd1;

    // A store, or a register write whose value comes from memory, needs the bus.
    function automatic logic is_mem_access(input logic       dw_en,
                                           input logic       rw_en,
                                           input logic [1:0] dsrs);
        return dw_en | (rw_en & (dsrs == SRS_OUT_MEM));
    endfunction

endpackage

// File: rtl/mem_access_stage_dbus_timeout_cnt.sv
// Bus wait counter. Counts cycles spent waiting for an ack; expired_o marks
// the last wait cycle that is still allowed, so the bus request is held for
// exactly 2^TIMEOUT_WIDTH-1 cycles before the stage gives up.
module mem_access_stage_dbus_timeout_cnt #(
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_arst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

    logic [TIMEOUT_WIDTH-1:0] cnt_q;
    logic [TIMEOUT_WIDTH-1:0] cnt_d;

    // Next count: clear wins over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST_WAIT);

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage. Passes ALU results straight through in one cycle,
// runs loads/stores over a req/ack data bus and stalls upstream while a
// transaction is outstanding. Bus transactions are never aborted by a kill.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | accepting a new instruction from execute every cycle
// WAIT    | bus request outstanding, waiting for ack or timeout
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DATA_ADDR_WIDTH  = 30,
    parameter int INSTR_ADDR_WIDTH = 30,
    parameter int PC_WIDTH         = INSTR_ADDR_WIDTH - 2,
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int TIMEOUT_WIDTH    = 8
) (
    input  logic                        i_clk,
    input  logic                        i_arst_n,
    input  logic [DATA_WIDTH-1:0]       i_alu_result,
    input  logic [DATA_WIDTH-1:0]       i_dout_b,
    input  logic                        i_dw_en_ex,
    input  logic [1:0]                  i_dsrs_out_ex,
    input  logic                        i_rw_en_ex,
    input  logic [REG_ADDR_WIDTH-1:0]   i_raddr_w_ex,
    input  logic                        i_eret_ex,
    input  logic [PC_WIDTH-1:0]         i_pc_ex_ma,
    input  logic                        i_ma_kill,
    output logic                        o_dbus_req,
    output logic                        o_dbus_we,
    output logic [DATA_ADDR_WIDTH-1:0]  o_dbus_addr,
    output logic [DATA_WIDTH-1:0]       o_dbus_wdata,
    input  logic                        i_dbus_ack,
    input  logic [DATA_WIDTH-1:0]       i_dbus_rdata,
    output logic                        o_stall,
    output logic [DATA_WIDTH-1:0]       o_wb_data,
    output logic                        o_rw_en_ma,
    output logic [REG_ADDR_WIDTH-1:0]   o_raddr_w_ma,
    output logic                        o_eret_ma,
    output logic [PC_WIDTH-1:0]         o_pc_ma,
    output logic                        o_addr_err,
    output logic                        o_bus_err
);

    state_e                      state_q;
    logic                        dbus_req_q;
    logic                        dbus_we_q;
    logic [DATA_ADDR_WIDTH-1:0]  dbus_addr_q;
    logic [DATA_WIDTH-1:0]       dbus_wdata_q;
    logic [DATA_WIDTH-1:0]       wb_data_q;
    logic                        rw_en_q;
    logic [REG_ADDR_WIDTH-1:0]   raddr_q;
    logic                        eret_q;
    logic [PC_WIDTH-1:0]         pc_q;
    logic                        addr_err_q;
    logic                        bus_err_q;
    logic                        cap_rw_en_q;
    logic [REG_ADDR_WIDTH-1:0]   cap_raddr_q;
    logic [PC_WIDTH-1:0]         cap_pc_q;

    logic access;
    logic misal;
    logic tmo_expired;

    assign access = is_mem_access(i_dw_en_ex, i_rw_en_ex, i_dsrs_out_ex);
    assign misal  = |i_alu_result[1:0];

    // Hold upstream while a new access is being launched or until the ack arrives.
    assign o_stall = (state_q == ST_WAIT) ? !i_dbus_ack
                                          : (!i_ma_kill & access & !misal);

    mem_access_stage_dbus_timeout_cnt #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_tmo (
        .i_clk     (i_clk),
        .i_arst_n  (i_arst_n),
        .clear_i   (state_q == ST_IDLE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmo_expired)
    );

    // Stage FSM with registered bus and writeback outputs.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q      <= ST_IDLE;
            dbus_req_q   <= 1'b0;
            dbus_we_q    <= 1'b0;
            dbus_addr_q  <= '0;
            dbus_wdata_q <= '0;
            wb_data_q    <= '0;
            rw_en_q      <= 1'b0;
            raddr_q      <= '0;
            eret_q       <= 1'b0;
            pc_q         <= '0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            cap_rw_en_q  <= 1'b0;
            cap_raddr_q  <= '0;
            cap_pc_q     <= '0;
        end else begin
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_ma_kill) begin
                        rw_en_q <= 1'b0;
                        eret_q  <= 1'b0;
                    end else if (!access) begin
                        wb_data_q <= i_alu_result;
                        rw_en_q   <= i_rw_en_ex;
                        raddr_q   <= i_raddr_w_ex;
                        eret_q    <= i_eret_ex;
                        pc_q      <= i_pc_ex_ma;
                    end else if (misal) begin
                        addr_err_q <= 1'b1;
                        rw_en_q    <= 1'b0;
                        eret_q     <= 1'b0;
                        pc_q       <= i_pc_ex_ma;
                    end else begin
                        dbus_req_q   <= 1'b1;
                        dbus_we_q    <= i_dw_en_ex;
                        dbus_addr_q  <= i_alu_result[DATA_WIDTH-1:2];
                        dbus_wdata_q <= i_dout_b;
                        cap_rw_en_q  <= i_rw_en_ex;
                        cap_raddr_q  <= i_raddr_w_ex;
                        cap_pc_q     <= i_pc_ex_ma;
                        rw_en_q      <= 1'b0;
                        eret_q       <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_dbus_ack) begin
                        dbus_req_q <= 1'b0;
                        if (!dbus_we_q) begin
                            wb_data_q <= i_dbus_rdata;
                        end
                        rw_en_q <= cap_rw_en_q & !dbus_we_q;
                        raddr_q <= cap_raddr_q;
                        pc_q    <= cap_pc_q;
                        state_q <= ST_IDLE;
                    end else if (tmo_expired) begin
                        dbus_req_q <= 1'b0;
                        bus_err_q  <= 1'b1;
                        rw_en_q    <= 1'b0;
                        pc_q       <= cap_pc_q;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_dbus_req   = dbus_req_q;
    assign o_dbus_we    = dbus_we_q;
    assign o_dbus_addr  = dbus_addr_q;
    assign o_dbus_wdata = dbus_wdata_q;
    assign o_wb_data    = wb_data_q;
    assign o_rw_en_ma   = rw_en_q;
    assign o_raddr_w_ma = raddr_q;
    assign o_eret_ma    = eret_q;
    assign o_pc_ma      = pc_q;
    assign o_addr_err   = addr_err_q;
    assign o_bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a small expected-result scoreboard.
// Runs with a 3-bit timeout counter so the bus timeout is 7 wait cycles.
module tb_mem_access_stage;

    localparam int DW  = 32;
    localparam int AW  = 30;
    localparam int PCW = 28;
    localparam int RW  = 5;
    localparam int TW  = 3;
    localparam int TMO = (1 << TW) - 1;

    logic           i_clk;
    logic           i_arst_n;
    logic [DW-1:0]  i_alu_result;
    logic [DW-1:0]  i_dout_b;
    logic           i_dw_en_ex;
    logic [1:0]     i_dsrs_out_ex;
    logic           i_rw_en_ex;
    logic [RW-1:0]  i_raddr_w_ex;
    logic           i_eret_ex;
    logic [PCW-1:0] i_pc_ex_ma;
    logic           i_ma_kill;
    logic           o_dbus_req;
    logic           o_dbus_we;
    logic [AW-1:0]  o_dbus_addr;
    logic [DW-1:0]  o_dbus_wdata;
    logic           i_dbus_ack;
    logic [DW-1:0]  i_dbus_rdata;
    logic           o_stall;
    logic [DW-1:0]  o_wb_data;
    logic           o_rw_en_ma;
    logic [RW-1:0]  o_raddr_w_ma;
    logic           o_eret_ma;
    logic [PCW-1:0] o_pc_ma;
    logic           o_addr_err;
    logic           o_bus_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0]  wb;
        logic           rw;
        logic [RW-1:0]  raddr;
        logic           eret;
        logic [PCW-1:0] pc;
        logic           aerr;
        logic           berr;
        int             reqc;
        int             stallc;
        logic           chk_data;
        logic           chk_pc;
    } exp_t;

    exp_t sb[$];

    mem_access_stage #(
        .DATA_WIDTH       (DW),
        .DATA_ADDR_WIDTH  (AW),
        .INSTR_ADDR_WIDTH (30),
        .PC_WIDTH         (PCW),
        .REG_ADDR_WIDTH   (RW),
        .TIMEOUT_WIDTH    (TW)
    ) dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_alu_result  (i_alu_result),
        .i_dout_b      (i_dout_b),
        .i_dw_en_ex    (i_dw_en_ex),
        .i_dsrs_out_ex (i_dsrs_out_ex),
        .i_rw_en_ex    (i_rw_en_ex),
        .i_raddr_w_ex  (i_raddr_w_ex),
        .i_eret_ex     (i_eret_ex),
        .i_pc_ex_ma    (i_pc_ex_ma),
        .i_ma_kill     (i_ma_kill),
        .o_dbus_req    (o_dbus_req),
        .o_dbus_we     (o_dbus_we),
        .o_dbus_addr   (o_dbus_addr),
        .o_dbus_wdata  (o_dbus_wdata),
        .i_dbus_ack    (i_dbus_ack),
        .i_dbus_rdata  (i_dbus_rdata),
        .o_stall       (o_stall),
        .o_wb_data     (o_wb_data),
        .o_rw_en_ma    (o_rw_en_ma),
        .o_raddr_w_ma  (o_raddr_w_ma),
        .o_eret_ma     (o_eret_ma),
        .o_pc_ma       (o_pc_ma),
        .o_addr_err    (o_addr_err),
        .o_bus_err     (o_bus_err)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_nop();
        i_dw_en_ex    = 1'b0;
        i_rw_en_ex    = 1'b0;
        i_dsrs_out_ex = 2'd0;
        i_eret_ex     = 1'b0;
        i_ma_kill     = 1'b0;
        i_dbus_ack    = 1'b0;
    endtask

    // ack_after: number of wait cycles without ack before ack (-1 = never).
    // kmode: 0 no kill, 1 kill on the issue cycle, 2 kill during wait.
    task automatic run(input string name,
                       input logic [DW-1:0] alu, input logic [DW-1:0] dout,
                       input logic dw, input logic [1:0] dsrs, input logic rw,
                       input logic [RW-1:0] raddr, input logic eret,
                       input logic [PCW-1:0] pc, input logic [DW-1:0] rdata,
                       input int ack_after, input int kmode, input logic ack_idle);
        exp_t e;
        exp_t got;
        logic acc, mis, tmo;
        int   wcnt, reqc, stc;
        bit   done;

        acc = dw | (rw & (dsrs == 2'd1));
        mis = (alu[1:0] != 2'b00);
        tmo = (ack_after < 0) || (ack_after >= TMO);
        e = '{wb: '0, rw: 1'b0, raddr: '0, eret: 1'b0, pc: pc, aerr: 1'b0,
              berr: 1'b0, reqc: 0, stallc: 0, chk_data: 1'b0, chk_pc: 1'b1};
        if (kmode == 1) begin
            e.chk_pc = 1'b0;
        end else if (!acc) begin
            e.wb = alu; e.rw = rw; e.raddr = raddr; e.eret = eret; e.chk_data = 1'b1;
        end else if (mis) begin
            e.aerr = 1'b1;
        end else if (tmo) begin
            e.berr = 1'b1; e.reqc = TMO; e.stallc = 1 + TMO;
        end else begin
            e.reqc = ack_after + 1; e.stallc = 1 + ack_after;
            if (!dw) begin
                e.wb = rdata; e.rw = 1'b1; e.raddr = raddr; e.chk_data = 1'b1;
            end
        end
        sb.push_back(e);

        i_alu_result  = alu;
        i_dout_b      = dout;
        i_dw_en_ex    = dw;
        i_dsrs_out_ex = dsrs;
        i_rw_en_ex    = rw;
        i_raddr_w_ex  = raddr;
        i_eret_ex     = eret;
        i_pc_ex_ma    = pc;
        i_dbus_rdata  = rdata;
        i_ma_kill     = (kmode == 1);

        wcnt = 0; reqc = 0; stc = 0; done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (o_dbus_req) begin
                if (wcnt == 0) begin
                    chk({name, ":dbus_we"}, o_dbus_we, dw);
                    chk({name, ":dbus_addr"}, o_dbus_addr, alu[DW-1:2]);
                    if (dw) chk({name, ":dbus_wdata"}, o_dbus_wdata, dout);
                end
                i_dbus_ack = (ack_after >= 0) && (wcnt == ack_after);
                if (kmode == 2) i_ma_kill = 1'b1;
            end else begin
                i_dbus_ack = ack_idle;
            end
            #3;
            if (o_stall) stc++;
            if (o_dbus_req) begin
                reqc++;
                wcnt++;
            end
            @(posedge i_clk);
            #1;
            if (!o_dbus_req) done = 1;
        end
        drive_nop();
        if (!done) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s:completion observed no-completion expected completion within 300 cycles", name);
        end

        got = sb.pop_front();
        chk({name, ":rw_en"},    o_rw_en_ma, got.rw);
        chk({name, ":eret"},     o_eret_ma,  got.eret);
        chk({name, ":addr_err"}, o_addr_err, got.aerr);
        chk({name, ":bus_err"},  o_bus_err,  got.berr);
        chk({name, ":req_cycles"},   reqc, got.reqc);
        chk({name, ":stall_cycles"}, stc,  got.stallc);
        if (got.chk_data) begin
            chk({name, ":wb_data"}, o_wb_data,    got.wb);
            chk({name, ":raddr"},   o_raddr_w_ma, got.raddr);
        end
        if (got.chk_pc) chk({name, ":pc"}, o_pc_ma, got.pc);

        // Error flags are single-cycle pulses; a bubble follows.
        @(posedge i_clk);
        #1;
        chk({name, ":addr_err_pulse"}, o_addr_err, 1'b0);
        chk({name, ":bus_err_pulse"},  o_bus_err,  1'b0);
        chk({name, ":req_idle"},       o_dbus_req, 1'b0);
    endtask

    initial begin
        i_arst_n     = 1'b0;
        i_alu_result = '0;
        i_dout_b     = '0;
        i_raddr_w_ex = '0;
        i_pc_ex_ma   = '0;
        i_dbus_rdata = '0;
        drive_nop();
        #12;
        chk("reset:req",      o_dbus_req,   1'b0);
        chk("reset:we",       o_dbus_we,    1'b0);
        chk("reset:addr",     o_dbus_addr,  '0);
        chk("reset:wb_data",  o_wb_data,    '0);
        chk("reset:rw_en",    o_rw_en_ma,   1'b0);
        chk("reset:pc",       o_pc_ma,      '0);
        chk("reset:addr_err", o_addr_err,   1'b0);
        chk("reset:bus_err",  o_bus_err,    1'b0);
        chk("reset:stall",    o_stall,      1'b0);
        #8 i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;

        //  name           alu           dout          dw    dsrs  rw    raddr eret  pc        rdata         ack kmode ack_idle
        run("alu_pass",    32'h1234,     32'h0,        1'b0, 2'd0, 1'b1, 5'd5, 1'b0, 28'h111, 32'h0,         0,  0, 1'b0);
        run("load_ack3",   32'h100,      32'h0,        1'b0, 2'd1, 1'b1, 5'd7, 1'b0, 28'h222, 32'hDEADBEEF, 3,  0, 1'b0);
        run("store_ack0",  32'h8,        32'hA5A5A5A5, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0, 28'h333, 32'h0,         0,  0, 1'b0);
        run("load_misal",  32'h102,      32'h0,        1'b0, 2'd1, 1'b1, 5'd9, 1'b0, 28'h444, 32'h0,         0,  0, 1'b0);
        run("store_misal", 32'h9,        32'h5A5A5A5A, 1'b1, 2'd0, 1'b0, 5'd0, 1'b0, 28'h445, 32'h0,         0,  0, 1'b0);
        run("timeout",     32'h200,      32'h0,        1'b0, 2'd1, 1'b1, 5'd3, 1'b0, 28'h555, 32'h12345678, -1, 0, 1'b0);
        run("ack_last",    32'h204,      32'h0,        1'b0, 2'd1, 1'b1, 5'd4, 1'b0, 28'h556, 32'hCAFEF00D, 6,  0, 1'b0);
        run("kill_idle",   32'h300,      32'h0,        1'b0, 2'd1, 1'b1, 5'd6, 1'b0, 28'h666, 32'h0,         0,  1, 1'b0);
        run("kill_wait",   32'h304,      32'h0,        1'b0, 2'd1, 1'b1, 5'd8, 1'b0, 28'h667, 32'h0BADF00D, 2,  2, 1'b0);
        run("alu_eret",    32'hFFFF0003, 32'h0,        1'b0, 2'd2, 1'b1, 5'd31,1'b1, 28'h777, 32'h0,         0,  0, 1'b1);
        run("r0_write",    32'h55,       32'h0,        1'b0, 2'd3, 1'b1, 5'd0, 1'b0, 28'h888, 32'h0,         0,  0, 1'b0);

        // Asynchronous reset while a load is waiting on the bus.
        i_alu_result  = 32'h400;
        i_dsrs_out_ex = 2'd1;
        i_rw_en_ex    = 1'b1;
        i_raddr_w_ex  = 5'd10;
        i_pc_ex_ma    = 28'h999;
        @(posedge i_clk);
        #1;
        chk("rst_wait:req_before", o_dbus_req, 1'b1);
        #2 i_arst_n = 1'b0;
        #1;
        chk("rst_wait:req",      o_dbus_req,   1'b0);
        chk("rst_wait:addr",     o_dbus_addr,  '0);
        chk("rst_wait:wb_data",  o_wb_data,    '0);
        chk("rst_wait:rw_en",    o_rw_en_ma,   1'b0);
        chk("rst_wait:pc",       o_pc_ma,      '0);
        chk("rst_wait:bus_err",  o_bus_err,    1'b0);
        drive_nop();
        #1 i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        run("after_reset", 32'hABCD, 32'h0, 1'b0, 2'd0, 1'b1, 5'd12, 1'b0, 28'hAAA, 32'h0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
